// File: rtl/dnoc_pingpong_ctrl.sv
// Ping-pong double-buffer controller: a producer fills one bank while a
// consumer drains the other, each bank tracking its own transfer length.
module dnoc_pingpong_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW:0]   cfg_len_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic          buf_wr_en_o,
  output logic [AW:0]   buf_wr_addr_o,
  output logic          wr_done_o,
  input  logic          rd_ready_i,
  output logic          buf_rd_en_o,
  output logic [AW:0]   buf_rd_addr_o,
  output logic          rd_data_vld_o,
  output logic          rd_done_o,
  output logic [1:0]    buf_state_o
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  localparam logic [AW:0] DepthW = DEPTH[AW:0];
  localparam logic [AW:0] LenOne = 1;

  bank_st_e    bank_q [2];
  bank_st_e    bank_d [2];
  logic [AW:0] len_q  [2];
  logic [AW:0] len_d  [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic        wr_done_q, rd_done_q, rd_vld_q;

  logic [AW:0] len_eff, wr_len, rd_len;
  bank_st_e    wr_st, rd_st;
  logic        wr_fire, wr_last, rd_fire, rd_last;

  // Zero or oversize lengths mean a full bank.
  assign len_eff = ((cfg_len_i == '0) || (cfg_len_i > DepthW)) ? DepthW : cfg_len_i;

  assign wr_st   = bank_q[wr_ptr_q];
  assign rd_st   = bank_q[rd_ptr_q];

  // A bank still EMPTY has not latched its length yet, so use the live value.
  assign wr_len  = (wr_st == StEmpty) ? len_eff : len_q[wr_ptr_q];
  assign rd_len  = len_q[rd_ptr_q];

  assign wr_ready_o  = !rst_i && ((wr_st == StEmpty) || (wr_st == StFilling));
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_last     = (wcnt_q == (wr_len - LenOne));
  assign buf_wr_en_o = wr_fire;

  assign buf_rd_en_o = !rst_i && rd_ready_i && ((rd_st == StFull) || (rd_st == StDraining));
  assign rd_fire     = buf_rd_en_o;
  assign rd_last     = (rcnt_q == (rd_len - LenOne));

  assign buf_wr_addr_o = rst_i ? '0 : {wr_ptr_q, wcnt_q[AW-1:0]};
  assign buf_rd_addr_o = rst_i ? '0 : {rd_ptr_q, rcnt_q[AW-1:0]};

  assign wr_done_o     = wr_done_q;
  assign rd_done_o     = rd_done_q;
  assign rd_data_vld_o = rd_vld_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      buf_state_o[i] = (bank_q[i] == StFull) || (bank_q[i] == StDraining);
    end
  end

  always_comb begin
    bank_d   = bank_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;

    // Write and read never target the same bank: their state sets are disjoint.
    if (wr_fire) begin
      if (wr_st == StEmpty) begin
        len_d[wr_ptr_q] = len_eff;
      end
      if (wr_last) begin
        bank_d[wr_ptr_q] = StFull;
        wcnt_d           = '0;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        bank_d[wr_ptr_q] = StFilling;
        wcnt_d           = wcnt_q + LenOne;
      end
    end

    if (rd_fire) begin
      if (rd_last) begin
        bank_d[rd_ptr_q] = StEmpty;
        rcnt_d           = '0;
        rd_ptr_d         = ~rd_ptr_q;
      end else begin
        bank_d[rd_ptr_q] = StDraining;
        rcnt_d           = rcnt_q + LenOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0] <= StEmpty;
      bank_q[1] <= StEmpty;
      len_q[0]  <= DepthW;
      len_q[1]  <= DepthW;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      wr_done_q <= wr_fire && wr_last;
      rd_done_q <= rd_fire && rd_last;
      rd_vld_q  <= rd_fire;
    end
  end

endmodule

// File: tb/tb_dnoc_pingpong_ctrl.sv
// Bench for dnoc_pingpong_ctrl: a bank-occupancy model predicts handshakes,
// addresses and pulses; a token scoreboard checks every beat comes out once, in order.
module tb_dnoc_pingpong_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   cfg_len;
  logic          wr_valid, rd_ready;
  logic          wr_ready, buf_wr_en, wr_done, buf_rd_en, rd_data_vld, rd_done;
  logic [AW:0]   buf_wr_addr, buf_rd_addr;
  logic [1:0]    buf_state;

  always #5 clk = ~clk;

  dnoc_pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_len_i     (cfg_len),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .buf_wr_en_o   (buf_wr_en),
    .buf_wr_addr_o (buf_wr_addr),
    .wr_done_o     (wr_done),
    .rd_ready_i    (rd_ready),
    .buf_rd_en_o   (buf_rd_en),
    .buf_rd_addr_o (buf_rd_addr),
    .rd_data_vld_o (rd_data_vld),
    .rd_done_o     (rd_done),
    .buf_state_o   (buf_state)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: banks are a FIFO of completed fills.
  int nw, nr, woff, roff, cur_wlen, token;
  int lenq[$];
  int expq[$];
  bit exp_wr_done, exp_rd_done, exp_vld;
  int mem [2*DEPTH];
  int rdata;

  function automatic int len_eff(input int c);
    return (c == 0 || c > int'(DEPTH)) ? int'(DEPTH) : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit wv, input bit rr, input int cfg);
    int  occ;
    bit  e_wrdy, e_wfire, e_ren;
    logic [1:0] e_bs;
    logic s_wen, s_ren;
    logic [AW:0] s_waddr, s_raddr;
    @(negedge clk);
    rst = r; wr_valid = wv; rd_ready = rr; cfg_len = cfg[AW:0];
    #1;
    occ     = nw - nr;
    e_wrdy  = !r && occ < 2;
    e_wfire = wv && e_wrdy;
    e_ren   = !r && rr && occ >= 1;
    e_bs    = 2'b00;
    for (int k = nr; k < nw; k++) e_bs[k % 2] = 1'b1;
    chk("wr_ready", wr_ready, e_wrdy);
    chk("buf_wr_en", buf_wr_en, e_wfire);
    chk("buf_rd_en", buf_rd_en, e_ren);
    chk("wr_done", wr_done, exp_wr_done);
    chk("rd_done", rd_done, exp_rd_done);
    chk("rd_data_vld", rd_data_vld, exp_vld);
    chk("buf_state", buf_state, e_bs);
    if (r) begin
      chk("wr_addr_rst", buf_wr_addr, 0);
      chk("rd_addr_rst", buf_rd_addr, 0);
    end else begin
      if (e_wfire) chk("wr_addr", buf_wr_addr, (nw % 2) * DEPTH + woff);
      if (e_ren)   chk("rd_addr", buf_rd_addr, (nr % 2) * DEPTH + roff);
    end
    s_wen = buf_wr_en; s_waddr = buf_wr_addr;
    s_ren = buf_rd_en; s_raddr = buf_rd_addr;
    @(posedge clk);
    if (s_wen === 1'b1) mem[s_waddr] = token;
    if (s_ren === 1'b1) rdata = mem[s_raddr];
    if (r) begin
      nw = 0; nr = 0; woff = 0; roff = 0;
      lenq.delete(); expq.delete();
      exp_wr_done = 0; exp_rd_done = 0; exp_vld = 0;
    end else begin
      exp_wr_done = 0; exp_rd_done = 0; exp_vld = e_ren;
      if (e_ren) begin
        if (roff == lenq[0] - 1) begin
          void'(lenq.pop_front()); nr++; roff = 0; exp_rd_done = 1;
        end else roff++;
      end
      if (e_wfire) begin
        if (woff == 0) cur_wlen = len_eff(cfg);
        expq.push_back(token);
        if (woff == cur_wlen - 1) begin
          lenq.push_back(cur_wlen); nw++; woff = 0; exp_wr_done = 1;
        end else woff++;
      end
    end
    token++;
  endtask

  // Scoreboard monitor: every valid read beat must carry the oldest outstanding token.
  always @(negedge clk) begin
    #2;
    if (rd_data_vld === 1'b1) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_data: got %0d expected none (no beat outstanding)", rdata);
      end else begin
        chk("rd_data", rdata, expq.pop_front());
      end
    end
  end

  initial begin
    nw = 0; nr = 0; woff = 0; roff = 0; cur_wlen = DEPTH; token = 1; rdata = 0;
    exp_wr_done = 0; exp_rd_done = 0; exp_vld = 0;
    for (int i = 0; i < 2*DEPTH; i++) mem[i] = 0;
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; cfg_len = '0;
    @(posedge clk);
    repeat (2) cycle(1, 0, 0, 4);
    // Fill both banks, then stall
    repeat (10) cycle(0, 1, 0, 4);
    // Drain both banks
    repeat (12) cycle(0, 0, 1, 4);
    // Concurrent streaming with two-beat banks
    repeat (80) cycle(0, 1, 1, 2);
    // Length edge cases
    repeat (16) cycle(0, 1, 1, 0);
    repeat (16) cycle(0, 1, 1, 7);
    repeat (12) cycle(0, 1, 1, 1);
    repeat (10) cycle(0, 0, 1, 1);
    // Length change mid-fill applies only to the next bank
    repeat (2) cycle(0, 1, 0, 4);
    repeat (8) cycle(0, 1, 0, 2);
    repeat (10) cycle(0, 0, 1, 2);
    // Reset in the middle of a transfer
    repeat (3) cycle(0, 1, 0, 2);
    cycle(0, 0, 1, 2);
    cycle(1, 1, 1, 2);
    repeat (4) cycle(0, 1, 0, 2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), $urandom_range(0, 7));
    end
    repeat (10) cycle(0, 0, 1, 4);
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
